// File: rtl/fb_port_arbiter_pkg.sv
// Shared definitions for the frame-buffer port arbiter.
//   arb_state_e : port-owner encodings (ST_IDLE / ST_READ / ST_WRITE)
//   RD_LATENCY  : posX/posY -> pixel_out latency, in clocks
//   DEF_*       : default pixel/address widths and image size. The capture
//                 and VGA top levels use the same values.
package fb_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_e;

    localparam int RD_LATENCY = 2;

    localparam int DEF_DW    = 12;
    localparam int DEF_AW    = 15;
    localparam int DEF_IMG_W = 160;
    localparam int DEF_IMG_H = 120;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write-request FIFO for the frame-buffer arbiter.
//   clk, rst        : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data : write an entry. Ignored while full, with no bypass.
//   pop             : discard the head entry. Ignored while empty.
//   head            : current head entry (valid when !empty)
//   full, empty     : status flags, decoded from (FIFO_AW+1)-bit pointers
module fb_wr_fifo #(
    parameter int W       = 27,
    parameter int FIFO_AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [W-1:0]     mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // The pointers carry an extra wrap bit. Equal low bits with a different
    // wrap bit means full. Equal pointers means empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage has no reset. After reset the pointers mark every entry as stale.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter. Display read-out and capture writes share
// one port.
// The display owns the port inside the image window. Capture writes wait in a
// FIFO and drain to the RAM whenever the display does not need the port.
//   clk, rst          : pixel clock; asynchronous active-high reset
//   posX, posY        : next pixel position from the VGA timing generator
//   pixel_out         : pixel to the VGA datapath, RD_LATENCY clocks after posX/posY
//   wr_valid/wr_ready : capture write handshake; carries wr_addr / wr_data
//   mem_addr/we/wdata : registered RAM controls
//   mem_rdata         : RAM read data, one clock after mem_addr
//   stall_cnt         : present only when FB_ARB_STATS_EN is defined. Counts
//                       cycles where a capture write was refused. Saturates,
//                       and clears at frame start (0,0).
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
#(
    parameter int          DW       = DEF_DW,
    parameter int          AW       = DEF_AW,
    parameter int          IMG_W    = DEF_IMG_W,
    parameter int          IMG_H    = DEF_IMG_H,
    parameter int          FIFO_AW  = 4,
    parameter logic [DW-1:0] BG_COLOR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    posX,
    input  logic [9:0]    posY,
    output logic [DW-1:0] pixel_out,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
`ifdef FB_ARB_STATS_EN
    output logic [15:0]   stall_cnt,
`endif
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [9:0]  IMG_W_L = 10'(IMG_W);
    localparam logic [9:0]  IMG_H_L = 10'(IMG_H);
    localparam logic [AW:0] NPIX    = (AW+1)'(IMG_W * IMG_H);

    // ---------------- write FIFO ----------------
    logic             fifo_full, fifo_empty, push, pop;
    logic [AW+DW-1:0] head;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;

    assign wr_ready = !fifo_full;
    assign push     = wr_valid && wr_ready;
    assign {head_addr, head_data} = head;

    fb_wr_fifo #(.W(AW+DW), .FIFO_AW(FIFO_AW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({wr_addr, wr_data}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- port owner ----------------
    logic        in_img;
    logic [19:0] rd_full;
    logic [AW-1:0] rd_addr;
    arb_state_e  state;

    assign in_img  = (posX < IMG_W_L) && (posY < IMG_H_L);
    assign rd_full = ({10'd0, posY} * 20'(IMG_W)) + {10'd0, posX};
    assign rd_addr = AW'(rd_full);

    // The owner is decided from the current inputs in every cycle. The port
    // controls below are the registered result. Entering the window
    // therefore stops the drain in that same cycle.
    always_comb begin
        state = ST_IDLE;
        if (in_img)           state = ST_READ;
        else if (!fifo_empty) state = ST_WRITE;
    end

    assign pop = (state == ST_WRITE);

    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (state)
            ST_READ: mem_addr_d = rd_addr;
            ST_WRITE: begin
                mem_addr_d  = head_addr;
                mem_wdata_d = head_data;
                // An entry whose address is outside the image is still popped,
                // but it never reaches the RAM.
                mem_we_d    = ({1'b0, head_addr} < NPIX);
            end
            default: ;
        endcase
    end

    // ---------------- read-latency pipe ----------------
    // img_pipe carries in_img alongside the RAM access. vld_pipe holds
    // pixel_out at 0 until a post-reset access has reached the end of the pipe.
    logic [RD_LATENCY-1:0] img_pipe_q, img_pipe_d;
    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;

    always_comb begin
        img_pipe_d = {img_pipe_q[RD_LATENCY-2:0], in_img};
        vld_pipe_d = {vld_pipe_q[RD_LATENCY-2:0], 1'b1};
    end

    always_comb begin
        pixel_out = '0;
        if (vld_pipe_q[RD_LATENCY-1])
            pixel_out = img_pipe_q[RD_LATENCY-1] ? mem_rdata : BG_COLOR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            img_pipe_q  <= '0;
            vld_pipe_q  <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            img_pipe_q  <= img_pipe_d;
            vld_pipe_q  <= vld_pipe_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

`ifdef FB_ARB_STATS_EN
    // ---------------- stall statistics ----------------
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (posX == 10'd0 && posY == 10'd0)
            stall_cnt_d = '0;
        else if (wr_valid && !wr_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Testbench for fb_port_arbiter. A queue-based model of the arbiter is compared
// with the DUT on every falling edge. Directed scenarios add literal expectations.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  posX = 10'd700, posY = 10'd500;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [14:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic [11:0] pixel_out;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;
`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    always #20 clk = ~clk;

    fb_port_arbiter dut (
        .clk(clk), .rst(rst), .posX(posX), .posY(posY), .pixel_out(pixel_out),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
`ifdef FB_ARB_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port RAM. Reads return the old data.
    logic [11:0] ram   [32768];
    logic [11:0] m_ram [32768];
    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i]   = 12'(i);
            m_ram[i] = 12'(i);
        end
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [14:0] a; logic [11:0] d; } ent_t;
    ent_t        q[$];
    ent_t        ent;
    logic        e_we = 1'b0;
    logic [14:0] e_addr = '0;
    logic [11:0] e_wdata = '0;
    logic [11:0] p0 = '0, p1 = '0;
    logic [15:0] e_stall = '0;
    int          n, ra;
    bit          img;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            e_we = 1'b0; e_addr = '0; e_wdata = '0;
            p0 = '0; p1 = '0; e_stall = '0;
        end else begin
            img = (posX < 160) && (posY < 120);
            ra  = int'(posY) * 160 + int'(posX);
            n   = q.size();
            p1  = p0;
            p0  = img ? m_ram[ra[14:0]] : 12'h000;
            if (posX == 0 && posY == 0) e_stall = '0;
            else if (wr_valid && n == 16 && e_stall != 16'hFFFF) e_stall++;
            if (img) begin
                e_we = 1'b0;
                e_addr = ra[14:0];
            end else if (n > 0) begin
                ent     = q.pop_front();
                e_addr  = ent.a;
                e_wdata = ent.d;
                e_we    = (ent.a < 15'd19200);
                if (e_we) m_ram[ent.a] = ent.d;
            end else begin
                e_we = 1'b0;
            end
            if (wr_valid && n < 16) q.push_back({wr_addr, wr_data});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_we",    32'(mem_we),    32'(e_we));
            chk("mem_addr",  32'(mem_addr),  32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            chk("wr_ready",  32'(wr_ready),  32'(q.size() < 16));
            chk("pixel_out", 32'(pixel_out), 32'(p1));
`ifdef FB_ARB_STATS_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(e_stall));
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Drives one cycle of inputs, reports whether the write was accepted, and
    // returns just after the clock edge that sampled them.
    task automatic cyc(input int x, input int y, input logic v,
                       input int a, input int d, output logic acc);
        posX = 10'(x); posY = 10'(y);
        wr_valid = v; wr_addr = 15'(a); wr_data = 12'(d);
        acc = v && wr_ready;
        @(posedge clk); #1;
    endtask

    logic acc;
    int   x;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_we",    32'(mem_we),    0);
        chk("reset mem_addr",  32'(mem_addr),  0);
        chk("reset pixel_out", 32'(pixel_out), 0);
        rst = 1'b0;
        chk("reset wr_ready",  32'(wr_ready),  1);
        cyc(700, 10, 0, 0, 0, acc);

        // Push during blanking: the write reaches the RAM one cycle later.
        cyc(700, 10, 1, 5, 12'hABC, acc);
        chk("t2 accepted", 32'(acc), 1);
        cyc(700, 10, 0, 0, 0, acc);
        chk("t2 mem_we",    32'(mem_we),    1);
        chk("t2 mem_addr",  32'(mem_addr),  5);
        chk("t2 mem_wdata", 32'(mem_wdata), 32'h0ABC);
        cyc(700, 10, 0, 0, 0, acc);

        // Push inside the window: the write waits for posX = 160.
        cyc(10, 0, 1, 7, 12'h777, acc);
        for (int i = 11; i < 160; i++) begin
            cyc(i, 0, 0, 0, 0, acc);
            chk("t3 held", 32'(mem_we), 0);
        end
        cyc(160, 0, 0, 0, 0, acc);
        chk("t3 mem_we",   32'(mem_we),   1);
        chk("t3 mem_addr", 32'(mem_addr), 7);
        cyc(161, 0, 0, 0, 0, acc);

        // 17 back-to-back pushes inside the window. The 17th waits until the drain starts.
        for (int i = 0; i < 16; i++) cyc(i, 1, 1, i, 12'h100 + i, acc);
        chk("t4 full", 32'(wr_ready), 0);
        x = 16;
        acc = 1'b0;
        while (!acc && x < 400) begin
            cyc(x, 1, 1, 16, 12'h110, acc);
            x++;
        end
        chk("t4 17th accepted at x", 32'(x - 1), 161);
`ifdef FB_ARB_STATS_EN
        chk("t4 stall_cnt", 32'(stall_cnt), 145);
`endif
        for (int i = 0; i < 20; i++) cyc(x + i, 1, 0, 0, 0, acc);

        // Read path, using the RAM image mem[i] = i.
        cyc(3, 2, 0, 0, 0, acc);
        chk("t5 mem_addr", 32'(mem_addr), 323);
        cyc(200, 2, 0, 0, 0, acc);
        chk("t5 pixel", 32'(pixel_out), 32'h143);
        cyc(200, 2, 0, 0, 0, acc);
        chk("t5 bg", 32'(pixel_out), 0);

        // Out-of-range entry is popped without a write. The next push goes straight through.
        cyc(700, 10, 1, 19200, 12'h5A5, acc);
        cyc(700, 10, 0, 0, 0, acc);
        chk("t6 mem_we", 32'(mem_we), 0);
        cyc(700, 10, 1, 9, 12'h999, acc);
        cyc(700, 10, 0, 0, 0, acc);
        chk("t6 next write", 32'(mem_we), 1);
        chk("t6 next addr",  32'(mem_addr), 9);

        // Reset while draining, with 3 entries queued.
        for (int i = 0; i < 3; i++) cyc(i, 3, 1, 100 + i, 12'h200 + i, acc);
        cyc(160, 3, 0, 0, 0, acc);
        chk("t1 draining", 32'(mem_we), 1);
        rst = 1'b1;
        #1;
        chk("t1 rst mem_we",    32'(mem_we),    0);
        chk("t1 rst pixel_out", 32'(pixel_out), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("t1 wr_ready", 32'(wr_ready), 1);
        for (int i = 0; i < 5; i++) begin
            cyc(170 + i, 3, 0, 0, 0, acc);
            chk("t1 no write", 32'(mem_we), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
